// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - end-of-test monitor: tohost store / ecall exit decode with cycle budget
// Sticky pass/fail/timeout status for riscv-tests style self-checking programs.
module tohost_monitor #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
   parameter int                MAX_TICKS   = 100000,
   parameter int                CNT_W       = $clog2(MAX_TICKS + 1),
   parameter bit                ECALL_EN    = 1'b1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   dmem_addr_i,
   input  logic [DATA_W/8-1:0] dmem_wsel_byte_i,
   input  logic [DATA_W-1:0]   dmem_wdata_i,
   input  logic                trap_i,
   input  logic [DATA_W-1:0]   gp_i,
   input  logic [DATA_W-1:0]   a7_i,
   input  logic [DATA_W-1:0]   a0_i,
   output logic                running_o,
   output logic                done_o,
   output logic                pass_o,
   output logic                fail_o,
   output logic                timeout_o,
   output logic [DATA_W-2:0]   fail_code_o,
   output logic [CNT_W-1:0]    ticks_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0]  TICKS_MAX  = CNT_W'(MAX_TICKS);
   localparam logic [CNT_W-1:0]  TICKS_LAST = CNT_W'(MAX_TICKS - 1);
   localparam logic [DATA_W-1:0] A7_EXIT    = DATA_W'(93);
   localparam logic [DATA_W-1:0] ONE_W      = DATA_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  ticks_q, ticks_d;
   logic [DATA_W-2:0] code_q, code_d;

   logic tohost_hit;
   logic tohost_pass;
   logic ecall_hit;
   logic ecall_pass;
   logic timeout_hit;
   logic addr_lsb_unused;

   // The word compare ignores the byte offset so sub-word stores to tohost still count.
   assign tohost_hit  = (|dmem_wsel_byte_i)
                     && (dmem_addr_i[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2])
                     && dmem_wdata_i[0];
   assign tohost_pass = (dmem_wdata_i == ONE_W);
   assign ecall_hit   = ECALL_EN && trap_i && (a7_i == A7_EXIT);
   assign ecall_pass  = (a0_i == '0) && (gp_i == ONE_W);
   assign timeout_hit = (ticks_q == TICKS_LAST);
   assign addr_lsb_unused = ^dmem_addr_i[1:0];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         ticks_q <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         ticks_q <= ticks_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ticks_d = ticks_q;
      code_d  = code_q;
      case (state_q)
         S_RUN: begin
            ticks_d = (ticks_q == TICKS_MAX) ? ticks_q : ticks_q + CNT_W'(1);
            if (start_i) begin
               ticks_d = '0;
               code_d  = '0;
            end else if (tohost_hit) begin
               if (tohost_pass) begin
                  state_d = S_PASS;
               end else begin
                  state_d = S_FAIL;
                  code_d  = dmem_wdata_i[DATA_W-1:1];
               end
            end else if (ecall_hit) begin
               if (ecall_pass) begin
                  state_d = S_PASS;
               end else begin
                  state_d = S_FAIL;
                  code_d  = gp_i[DATA_W-1:1];
               end
            end else if (timeout_hit) begin
               state_d = S_TIMEOUT;
            end
         end
         default: begin
            // IDLE and all terminal states only leave on a fresh start.
            if (start_i) begin
               state_d = S_RUN;
               ticks_d = '0;
               code_d  = '0;
            end
         end
      endcase
   end

   always_comb begin
      running_o   = (state_q == S_RUN);
      pass_o      = (state_q == S_PASS);
      fail_o      = (state_q == S_FAIL);
      timeout_o   = (state_q == S_TIMEOUT);
      done_o      = pass_o || fail_o || timeout_o;
      fail_code_o = (state_q == S_FAIL) ? code_q : '0;
      ticks_o     = ticks_q;
   end

endmodule

// File: tb/tb_tohost_monitor.sv
// tb/tb_tohost_monitor.sv - scoreboard bench for tohost_monitor
`timescale 1ns/1ps
module tb_tohost_monitor;

   localparam logic [4:0] F_IDLE = 5'b00000;
   localparam logic [4:0] F_RUN  = 5'b10000;
   localparam logic [4:0] F_PASS = 5'b01100;
   localparam logic [4:0] F_FAIL = 5'b01010;
   localparam logic [4:0] F_TO   = 5'b01001;
   localparam logic [31:0] TOHOST = 32'h8000_1000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  wsel = '0;
   logic [31:0] wdata = '0;
   logic        trap = 1'b0;
   logic [31:0] gp = '0;
   logic [31:0] a7 = '0;
   logic [31:0] a0 = '0;

   logic        run_a, done_a, pass_a, fail_a, to_a;
   logic [30:0] code_a;
   logic [6:0]  ticks_a;
   logic        run_b, done_b, pass_b, fail_b, to_b;
   logic [30:0] code_b;
   logic [4:0]  ticks_b;

   always #5 clk = ~clk;

   tohost_monitor #(.MAX_TICKS(100)) u_a (
      .clk_i(clk), .rstn_i(rstn), .start_i(start_a),
      .dmem_addr_i(addr), .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata),
      .trap_i(trap), .gp_i(gp), .a7_i(a7), .a0_i(a0),
      .running_o(run_a), .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
      .timeout_o(to_a), .fail_code_o(code_a), .ticks_o(ticks_a)
   );

   tohost_monitor #(.MAX_TICKS(20), .ECALL_EN(1'b0)) u_b (
      .clk_i(clk), .rstn_i(rstn), .start_i(start_b),
      .dmem_addr_i(addr), .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata),
      .trap_i(trap), .gp_i(gp), .a7_i(a7), .a0_i(a0),
      .running_o(run_b), .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
      .timeout_o(to_b), .fail_code_o(code_b), .ticks_o(ticks_b)
   );

   typedef struct {
      string      name;
      logic [4:0] flg;
      int         code;
      int         ticks;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   total = 0;
   int   bad = 0;
   bit   snap_a = 1'b0;
   bit   snap_b = 1'b0;
   bit   done_pa = 1'b0;
   bit   done_pb = 1'b0;

   task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s %s: got %0h expected %0h", nm, what, act, want);
      end
   endtask

   task automatic check_exp(input exp_t e, input logic [4:0] f, input logic [31:0] code, input logic [31:0] tk);
      cmp(e.name, "flags{run,done,pass,fail,timeout}", 32'(f), 32'(e.flg));
      cmp(e.name, "fail_code", code, e.code);
      cmp(e.name, "ticks", tk, e.ticks);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if ((done_a && !done_pa) || snap_a) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL unit_a unexpected output event");
         end else begin
            e = qa.pop_front();
            check_exp(e, {run_a, done_a, pass_a, fail_a, to_a}, 32'(code_a), 32'(ticks_a));
         end
      end
      if ((done_b && !done_pb) || snap_b) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL unit_b unexpected output event");
         end else begin
            e = qb.pop_front();
            check_exp(e, {run_b, done_b, pass_b, fail_b, to_b}, 32'(code_b), 32'(ticks_b));
         end
      end
      done_pa = done_a;
      done_pb = done_b;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_u(input int u, input string nm, input logic [4:0] f, input int code, input int tk);
      exp_t e;
      e.name = nm; e.flg = f; e.code = code; e.ticks = tk;
      if (u == 0) qa.push_back(e);
      else qb.push_back(e);
   endtask

   task automatic snap(input logic [1:0] m);
      snap_a = m[0];
      snap_b = m[1];
      @(negedge clk);
      #1;
      snap_a = 1'b0;
      snap_b = 1'b0;
   endtask

   task automatic store(input logic [31:0] ad, input logic [3:0] ws, input logic [31:0] d);
      addr = ad; wsel = ws; wdata = d;
   endtask

   task automatic do_trap(input logic [31:0] r17, input logic [31:0] r10, input logic [31:0] r3);
      trap = 1'b1; a7 = r17; a0 = r10; gp = r3;
   endtask

   task automatic idle_bus();
      wsel = '0; wdata = '0; addr = '0; trap = 1'b0;
   endtask

   task automatic arm(input int u);
      if (u == 0) start_a = 1'b1;
      else start_b = 1'b1;
      cyc(1);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      exp_t e;
      cyc(2);
      rstn = 1'b1;
      expect_u(0, "reset_a", F_IDLE, 0, 0);
      expect_u(1, "reset_b", F_IDLE, 0, 0);
      snap(2'b11);

      arm(0);
      cyc(49);
      store(TOHOST, 4'hF, 32'h1);
      expect_u(0, "tohost_pass", F_PASS, 0, 50);
      cyc(1);
      store(TOHOST, 4'hF, 32'hB);
      cyc(1);
      idle_bus();
      cyc(2);
      expect_u(0, "pass_sticky", F_PASS, 0, 50);
      snap(2'b01);

      arm(0);
      expect_u(0, "rearm_from_pass", F_RUN, 0, 0);
      snap(2'b01);

      cyc(9);
      store(TOHOST, 4'hF, 32'hB);
      expect_u(0, "tohost_fail", F_FAIL, 5, 10);
      cyc(1);
      idle_bus();
      cyc(2);
      store(TOHOST, 4'hF, 32'h1);
      cyc(1);
      idle_bus();
      expect_u(0, "fail_sticky", F_FAIL, 5, 10);
      snap(2'b01);

      arm(0);
      cyc(4);
      do_trap(32'd93, 32'd0, 32'd1);
      expect_u(0, "ecall_pass", F_PASS, 0, 5);
      cyc(1);
      idle_bus();

      arm(0);
      cyc(2);
      do_trap(32'd93, 32'd1, 32'd7);
      expect_u(0, "ecall_fail", F_FAIL, 3, 3);
      cyc(1);
      idle_bus();

      arm(0);
      store(TOHOST + 32'd4, 4'hF, 32'h1);
      cyc(1);
      store(TOHOST, 4'h0, 32'h1);
      cyc(1);
      store(TOHOST + 32'd2, 4'h2, 32'h1);
      expect_u(0, "subword_pass", F_PASS, 0, 3);
      cyc(1);
      idle_bus();

      arm(0);
      cyc(3);
      store(TOHOST, 4'hF, 32'h1);
      do_trap(32'd93, 32'd0, 32'd3);
      expect_u(0, "tohost_beats_ecall", F_PASS, 0, 4);
      cyc(1);
      idle_bus();

      arm(0);
      cyc(30);
      expect_u(0, "run_at_30", F_RUN, 0, 30);
      snap(2'b01);
      arm(0);
      expect_u(0, "restart_mid_run", F_RUN, 0, 0);
      snap(2'b01);

      start_a = 1'b1;
      store(TOHOST, 4'hF, 32'h1);
      cyc(1);
      start_a = 1'b0;
      idle_bus();
      expect_u(0, "start_beats_tohost", F_RUN, 0, 0);
      snap(2'b01);

      cyc(5);
      #2;
      rstn = 1'b0;
      expect_u(0, "async_reset_mid_run", F_IDLE, 0, 0);
      snap(2'b01);
      rstn = 1'b1;

      store(TOHOST, 4'hF, 32'h1);
      do_trap(32'd93, 32'd0, 32'd1);
      cyc(3);
      idle_bus();
      expect_u(0, "idle_ignores_events", F_IDLE, 0, 0);
      snap(2'b01);

      arm(1);
      store(TOHOST, 4'hF, 32'h0);
      cyc(1);
      idle_bus();
      do_trap(32'd64, 32'd0, 32'd1);
      cyc(1);
      do_trap(32'd93, 32'd0, 32'd1);
      cyc(1);
      idle_bus();
      expect_u(1, "ignored_events_b", F_RUN, 0, 3);
      snap(2'b10);
      cyc(16);
      expect_u(1, "run_at_last_tick", F_RUN, 0, 19);
      snap(2'b10);
      expect_u(1, "timeout", F_TO, 0, 20);
      cyc(1);
      cyc(2);

      arm(1);
      cyc(19);
      store(TOHOST, 4'hF, 32'hB);
      expect_u(1, "fail_beats_timeout", F_FAIL, 5, 20);
      cyc(1);
      idle_bus();
      cyc(2);

      start_b = 1'b1;
      store(TOHOST, 4'hF, 32'h1);
      cyc(1);
      start_b = 1'b0;
      idle_bus();
      expect_u(1, "start_from_fail", F_RUN, 0, 0);
      snap(2'b10);

      cyc(2);
      while (qa.size() > 0) begin
         e = qa.pop_front();
         total++; bad++;
         $display("FAIL %s no output event seen", e.name);
      end
      while (qb.size() > 0) begin
         e = qb.pop_front();
         total++; bad++;
         $display("FAIL %s no output event seen", e.name);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
